// File: rtl/icache_req_arb.sv
// Round-robin arbiter for the shared icache request path. Holds the grant
// across multi-beat bursts and registers the selected beat into a one-entry slot.
module icache_req_arb #(
  parameter int REQ_NUM   = 4,
  parameter int PLD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_NUM-1:0]   req_vld,
  input  logic [REQ_NUM-1:0]   req_last,
  input  logic [PLD_WIDTH-1:0] req_pld [REQ_NUM-1:0],
  output logic [REQ_NUM-1:0]   req_rdy,
  output logic                 out_vld,
  output logic [PLD_WIDTH-1:0] out_pld,
  output logic [REQ_NUM-1:0]   out_src,
  output logic                 out_last,
  input  logic                 out_rdy,
  output logic                 busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [REQ_NUM-1:0]   ptr_q, ptr_d;
  logic [REQ_NUM-1:0]   owner_q, owner_d;
  logic [REQ_NUM-1:0]   src_q, src_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic [PLD_WIDTH-1:0] pld_q, pld_d;

  logic                 slot_free;
  logic                 accept;
  logic                 grant_last;
  logic [REQ_NUM-1:0]   grant;
  logic [REQ_NUM-1:0]   rr_grant;
  logic [REQ_NUM-1:0]   hi_vld;
  logic [PLD_WIDTH-1:0] mux_pld;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    hi_vld   = req_vld & ~(ptr_q - REQ_NUM'(1));
    rr_grant = (hi_vld != '0) ? (hi_vld & (~hi_vld + REQ_NUM'(1)))
                              : (req_vld & (~req_vld + REQ_NUM'(1)));
    grant      = (state_q == LOCKED) ? (owner_q & req_vld) : rr_grant;
    slot_free  = !vld_q || out_rdy;
    req_rdy    = rst_n ? (grant & {REQ_NUM{slot_free}}) : '0;
    accept     = |(req_vld & req_rdy);
    grant_last = |(req_last & grant);
    mux_pld    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      mux_pld = mux_pld | (req_pld[i] & {PLD_WIDTH{grant[i]}});
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    vld_d   = vld_q;
    pld_d   = pld_q;
    src_d   = src_q;
    last_d  = last_q;
    if (accept) begin
      vld_d  = 1'b1;
      pld_d  = mux_pld;
      src_d  = grant;
      last_d = grant_last;
      if (grant_last) begin
        state_d = IDLE;
        ptr_d   = {grant[REQ_NUM-2:0], grant[REQ_NUM-1]};
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = grant;
      end
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= REQ_NUM'(1);
      owner_q <= '0;
      vld_q   <= 1'b0;
      pld_q   <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
      pld_q   <= pld_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_pld  = pld_q;
  assign out_src  = src_q;
  assign out_last = last_q;
  assign busy     = (state_q == LOCKED) || vld_q;

endmodule
